// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - RV32M multiply opcode encodings shared by the multiply unit and its users
package rv32m_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [OP_W-1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [OP_W-1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [OP_W-1:0] MUL_OP_MULHU  = 2'b11;

endpackage

// File: rtl/rv32m_mul_unit_mul32u.sv
// rtl/rv32m_mul_unit_mul32u.sv - combinational 32x32 unsigned multiplier array, 64-bit product
module mul32u (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    assign p = {32'd0, a} * {32'd0, b};

endmodule

// File: rtl/rv32m_mul_unit.sv
// rtl/rv32m_mul_unit.sv - two-stage pipelined RV32M multiply unit with valid/ready on both sides
module rv32m_mul_unit
    import rv32m_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_mag1_q,  s1_mag1_d;
    logic [31:0]      s1_mag2_q,  s1_mag2_d;
    logic             s1_neg_q,   s1_neg_d;
    logic [OP_W-1:0]  s1_op_q,    s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_res_q,   out_res_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    logic        s2_free;
    logic        accept;
    logic        s1_adv;
    logic        sign1;
    logic        sign2;
    logic [63:0] prod;
    logic [63:0] prod_signed;
    logic [31:0] res_sel;

    mul32u u_mul32u (
        .a (s1_mag1_q),
        .b (s1_mag2_q),
        .p (prod)
    );

    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        // A flushed or resetting cycle must never accept, so the offered request is dropped.
        in_ready = !flush && !rst && (!s1_valid_q || s2_free);
        accept   = in_valid && in_ready;
        s1_adv   = s1_valid_q && s2_free;

        sign1 = ((in_op == MUL_OP_MULH) || (in_op == MUL_OP_MULHSU)) && in_op1[31];
        sign2 = (in_op == MUL_OP_MULH) && in_op2[31];

        prod_signed = s1_neg_q ? (~prod + 64'd1) : prod;
        res_sel     = (s1_op_q == MUL_OP_MUL) ? prod_signed[31:0] : prod_signed[63:32];
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mag1_d   = s1_mag1_q;
        s1_mag2_d   = s1_mag2_q;
        s1_neg_d    = s1_neg_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_tag_d   = out_tag_q;

        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_res_d   = res_sel;
            out_tag_d   = s1_tag_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_mag1_d  = sign1 ? (~in_op1 + 32'd1) : in_op1;
            s1_mag2_d  = sign2 ? (~in_op2 + 32'd1) : in_op2;
            s1_neg_d   = sign1 ^ sign2;
            s1_op_d    = in_op;
            s1_tag_d   = in_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mag1_q   <= '0;
            s1_mag2_q   <= '0;
            s1_neg_q    <= 1'b0;
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mag1_q   <= s1_mag1_d;
            s1_mag2_q   <= s1_mag2_d;
            s1_neg_q    <= s1_neg_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_tag   = out_tag_q;

endmodule
